// File: rtl/multicycle_control_fsm.sv
// Multicycle ARM-subset control unit: instruction sequencing FSM, NZCV flag
// register and conditional-execution gating of the datapath write enables.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] Condition,
  input  logic [3:0] ALU_flags,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t     state_q;
  state_t     state_nxt;
  logic [3:0] nzcv_q;
  logic       cond_q;
  logic       cond_ex;
  logic       cond_use;
  logic [1:0] alu_ctl;
  logic       no_write;
  logic       cmd_ok;
  logic       cmd_cv;

  // ARM condition field evaluated against {N,Z,C,V}
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = cy;
      4'b0011: r = ~cy;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = cy & ~z;
      4'b1001: r = ~cy | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = z | (n != v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign cond_ex = cond_eval(Condition, nzcv_q);
  // ALUWB must see the condition as it was before EXEC possibly rewrote the flags
  assign cond_use = (state_q == S_ALUWB) ? cond_q : cond_ex;
  assign state    = state_q;

  // Data-processing cmd decode; unsupported cmds fall back to a harmless ADD
  always_comb begin
    alu_ctl  = 2'b00;
    no_write = 1'b1;
    cmd_ok   = 1'b0;
    cmd_cv   = 1'b0;
    case (Funct[4:1])
      4'b0100: begin alu_ctl = 2'b00; no_write = 1'b0; cmd_ok = 1'b1; cmd_cv = 1'b1; end
      4'b0010: begin alu_ctl = 2'b01; no_write = 1'b0; cmd_ok = 1'b1; cmd_cv = 1'b1; end
      4'b0000: begin alu_ctl = 2'b10; no_write = 1'b0; cmd_ok = 1'b1; end
      4'b1100: begin alu_ctl = 2'b11; no_write = 1'b0; cmd_ok = 1'b1; end
      4'b1010: begin alu_ctl = 2'b01; no_write = 1'b1; cmd_ok = 1'b1; cmd_cv = 1'b1; end
      default: ;
    endcase
  end

  // Next-state selection from the current state and instruction class
  always_comb begin
    state_nxt = S_FETCH;
    case (state_q)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00:   state_nxt = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_nxt = S_MEMADR;
          2'b10:   state_nxt = S_BRANCH;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR: state_nxt = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_nxt = S_MEMWB;
      S_EXECR:  state_nxt = S_ALUWB;
      S_EXECI:  state_nxt = S_ALUWB;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // State register; reset aborts whatever instruction is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_nxt;
  end

  // Flag register, written only on the edge that leaves EXECR/EXECI
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzcv_q <= 4'b0000;
      cond_q <= 1'b0;
    end else if (state_q == S_EXECR || state_q == S_EXECI) begin
      cond_q <= cond_ex;
      if (cond_ex && Funct[0] && cmd_ok) begin
        nzcv_q[3:2] <= ALU_flags[3:2];
        if (cmd_cv) nzcv_q[1:0] <= ALU_flags[1:0];
      end
    end
  end

  // Datapath controls decoded from the current state; writes held off in reset
  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1; PCWrite = 1'b1; ALUSrcA = 1'b1;
        ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01; RegWrite = cond_use;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1; MemWrite = cond_use;
      end
      S_EXECR: ALUControl = alu_ctl;
      S_EXECI: begin
        ALUSrcB = 2'b01; ALUControl = alu_ctl;
      end
      S_ALUWB: begin
        ALUControl = alu_ctl;
        RegWrite   = cond_use & ~no_write;
        PCWrite    = cond_use & ~no_write & (Rd == 4'd15);
      end
      S_BRANCH: begin
        ALUSrcB = 2'b01; ResultSrc = 2'b10; PCWrite = cond_use;
      end
      default: ;
    endcase
    if (!rst_n) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: instruction-level model of state sequence,
// flag register and conditional writes, checked every cycle.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd, Condition, ALU_flags;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ALUControl;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Rd(Rd),
    .Condition(Condition), .ALU_flags(ALU_flags),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .state(state)
  );

  localparam logic [11:0] M_W    = 12'hF00;
  localparam logic [11:0] M_ADR  = 12'h080;
  localparam logic [11:0] M_SRCA = 12'h040;
  localparam logic [11:0] M_SRCB = 12'h030;
  localparam logic [11:0] M_RES  = 12'h00C;
  localparam logic [11:0] M_ALU  = 12'h003;
  localparam int NOAB = -1;

  int checks = 0;
  int errors = 0;

  logic        exp_valid = 1'b0;
  logic [3:0]  e_state;
  logic [11:0] e_val, e_care;
  logic [19:0] trace = '0;
  logic [11:0] obs_q [16];
  logic [3:0]  mflags;

  wire [11:0] dut_outs = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
                          ALUSrcB, ResultSrc, ALUControl};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Condition codes come in complementary pairs; 1110/1111 are "always"/"never"
  function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? ~base : base;
  endfunction

  // cmd -> {ALUControl[1:0], NoWrite, supported, updates C/V}
  function automatic logic [4:0] m_dec(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 5'b00_0_1_1;
      4'b0010: return 5'b01_0_1_1;
      4'b0000: return 5'b10_0_1_0;
      4'b1100: return 5'b11_0_1_0;
      4'b1010: return 5'b01_1_1_1;
      default: return 5'b00_1_0_0;
    endcase
  endfunction

  function automatic void expect_for(input logic [3:0] st, input logic [3:0] cmd,
                                     input logic [3:0] rd, input logic cex,
                                     output logic [11:0] v, output logic [11:0] m);
    logic [4:0] d;
    logic pcw, irw, rw, mw, adr, srca, nw;
    logic [1:0] srcb, res, alu, dalu;
    d = m_dec(cmd);
    dalu = d[4:3];
    nw = d[2];
    {pcw, irw, rw, mw, adr, srca} = '0;
    srcb = 2'b00; res = 2'b00; alu = 2'b00;
    m = M_W;
    case (st)
      4'd0: begin pcw = 1; irw = 1; srca = 1; srcb = 2'b10; res = 2'b10; m = 12'hFFF; end
      4'd1: begin srca = 1; srcb = 2'b10; res = 2'b10; m = m | M_SRCA | M_SRCB | M_RES; end
      4'd2: begin srcb = 2'b01; m = m | M_SRCA | M_SRCB | M_ALU; end
      4'd3: begin adr = 1; m = m | M_ADR; end
      4'd4: begin res = 2'b01; rw = cex; m = m | M_RES; end
      4'd5: begin adr = 1; mw = cex; m = m | M_ADR; end
      4'd6: begin alu = dalu; m = m | M_SRCA | M_SRCB | M_ALU; end
      4'd7: begin srcb = 2'b01; alu = dalu; m = m | M_SRCA | M_SRCB | M_ALU; end
      4'd8: begin
        alu = dalu; rw = cex & ~nw; pcw = cex & ~nw & (rd == 4'd15);
        m = m | M_RES | M_ALU;
      end
      default: begin srcb = 2'b01; res = 2'b10; pcw = cex; m = m | M_SRCA | M_SRCB | M_RES | M_ALU; end
    endcase
    v = {pcw, irw, rw, mw, adr, srca, srcb, res, alu};
  endfunction

  // Compare process: DUT outputs against the model on every checked cycle
  initial begin
    forever begin
      @(negedge clk);
      if (exp_valid) begin
        chk($sformatf("state_exp%0d", e_state), {28'd0, state}, {28'd0, e_state});
        chk($sformatf("outs_st%0d", e_state), {20'd0, dut_outs & e_care}, {20'd0, e_val & e_care});
        trace = {trace[15:0], state};
        obs_q[state] = dut_outs;
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, {28'd0, state}, 32'd0);
    chk({tag, "_writes"}, {28'd0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'd0);
    chk({tag, "_mux"}, {24'd0, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}, {24'd0, 8'b0_1_10_10_00});
  endtask

  task automatic do_cycle(input logic [3:0] st, input logic [3:0] cmd, input logic [3:0] rd,
                          input logic cex, input logic [3:0] aluf);
    logic [11:0] v, m;
    expect_for(st, cmd, rd, cex, v, m);
    e_state = st; e_val = v; e_care = m;
    ALU_flags = aluf;
    exp_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  // Issue one instruction starting in FETCH; optionally pulse reset in state abort_st
  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                           input logic [3:0] cond, input logic [3:0] aluf, input logic use_aluf,
                           input int abort_st);
    logic [3:0] seq[$];
    logic cex;
    logic [4:0] d;
    logic [3:0] af;
    seq.push_back(4'd0);
    seq.push_back(4'd1);
    case (op)
      2'b00: begin seq.push_back(funct[5] ? 4'd7 : 4'd6); seq.push_back(4'd8); end
      2'b01: begin
        seq.push_back(4'd2);
        if (funct[0]) begin seq.push_back(4'd3); seq.push_back(4'd4); end
        else seq.push_back(4'd5);
      end
      2'b10: seq.push_back(4'd9);
      default: ;
    endcase
    Op = op; Funct = funct; Rd = rd; Condition = cond;
    cex = m_cond(cond, mflags);
    d = m_dec(funct[4:1]);
    foreach (seq[i]) begin
      af = use_aluf ? aluf : 4'($urandom);
      if (int'(seq[i]) == abort_st) begin
        e_state = seq[i];
        begin
          logic [11:0] v, m;
          expect_for(seq[i], funct[4:1], rd, cex, v, m);
          e_val = v; e_care = m;
        end
        ALU_flags = af;
        exp_valid = 1'b1;
        @(negedge clk); #2;
        exp_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset("abort_now");
        mflags = 4'b0000;
        @(posedge clk); #1;
        chk_reset("abort_hold");
        rst_n = 1'b1;
        return;
      end
      do_cycle(seq[i], funct[4:1], rd, cex, af);
      if ((seq[i] == 4'd6 || seq[i] == 4'd7) && cex && funct[0] && d[1]) begin
        mflags[3:2] = af[3:2];
        if (d[0]) mflags[1:0] = af[1:0];
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; Condition = 4'hE; ALU_flags = 4'd0;
    mflags = 4'b0000;
    #12;
    chk_reset("reset_async");
    @(posedge clk); #1;
    chk_reset("reset_edge");
    rst_n = 1'b1;

    // model pins
    chk("pin_cond_hi", {31'd0, m_cond(4'b1000, 4'b0010)}, 32'd1);
    chk("pin_cond_ls", {31'd0, m_cond(4'b1001, 4'b0110)}, 32'd1);
    chk("pin_cond_le", {31'd0, m_cond(4'b1101, 4'b1000)}, 32'd1);
    chk("pin_cond_nv", {31'd0, m_cond(4'b1111, 4'b0000)}, 32'd0);

    // ADD immediate, S=0, AL
    run_instr(2'b00, 6'b101000, 4'd1, 4'hE, 4'd0, 1'b0, NOAB);
    chk("add_trace", {16'd0, trace[15:0]}, 32'h0178);
    chk("add_rw_aluwb", {31'd0, obs_q[8][9]}, 32'd1);
    chk("add_rw_execi", {31'd0, obs_q[7][9]}, 32'd0);

    // CMP register with ALU_flags 0110
    run_instr(2'b00, 6'b010101, 4'd2, 4'hE, 4'b0110, 1'b1, NOAB);
    chk("cmp_trace", {16'd0, trace[15:0]}, 32'h0168);
    chk("cmp_rw_aluwb", {31'd0, obs_q[8][9]}, 32'd0);
    chk("pin_model_flags", {28'd0, mflags}, 32'h6);

    // B EQ then B NE
    run_instr(2'b10, 6'b000000, 4'd0, 4'h0, 4'd0, 1'b0, NOAB);
    chk("beq_pcw", {31'd0, obs_q[9][11]}, 32'd1);
    run_instr(2'b10, 6'b000000, 4'd0, 4'h1, 4'd0, 1'b0, NOAB);
    chk("bne_pcw", {31'd0, obs_q[9][11]}, 32'd0);

    // LDR and STR, AL
    run_instr(2'b01, 6'b011001, 4'd3, 4'hE, 4'd0, 1'b0, NOAB);
    chk("ldr_trace", {12'd0, trace}, 32'h01234);
    chk("ldr_adr_memrd", {31'd0, obs_q[3][7]}, 32'd1);
    chk("ldr_res_memwb", {30'd0, obs_q[4][3:2]}, 32'd1);
    chk("ldr_rw_memwb", {31'd0, obs_q[4][9]}, 32'd1);
    run_instr(2'b01, 6'b011000, 4'd3, 4'hE, 4'd0, 1'b0, NOAB);
    chk("str_trace", {16'd0, trace[15:0]}, 32'h0125);
    chk("str_mw_memwr", {31'd0, obs_q[5][8]}, 32'd1);

    // ADD to PC
    run_instr(2'b00, 6'b001000, 4'd15, 4'hE, 4'd0, 1'b0, NOAB);
    chk("addpc_pcw", {31'd0, obs_q[8][11]}, 32'd1);
    chk("addpc_rw", {31'd0, obs_q[8][9]}, 32'd1);

    // Reset pulse during MEMWR, then a normal instruction
    run_instr(2'b01, 6'b011000, 4'd4, 4'hE, 4'd0, 1'b0, 5);
    chk("abort_mw_seen", {31'd0, obs_q[5][8]}, 32'd1);
    run_instr(2'b00, 6'b101000, 4'd1, 4'h0, 4'd0, 1'b0, NOAB);

    // Every condition against every flag value
    for (int f = 0; f < 16; f++) begin
      run_instr(2'b00, 6'b010101, 4'd0, 4'hE, 4'(f), 1'b1, NOAB);
      for (int c = 0; c < 16; c++)
        run_instr(2'b10, 6'b000000, 4'd0, 4'(c), 4'd0, 1'b0, NOAB);
    end

    // Random instruction stream with occasional reset pulses
    for (int k = 0; k < 300; k++) begin
      logic [3:0] cnd;
      int ab;
      cnd = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom);
      ab = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 9)) : NOAB;
      run_instr(2'($urandom), 6'($urandom), ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom),
                cnd, 4'd0, 1'b0, ab);
    end

    exp_valid = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
